adc_spi_responder: RTL and testbench

Synthesizable SPI responder that emulates the DE1-SoC onboard 8-channel, 12-bit serial ADC (AD7928-style framing). It sits at the far end of the ADC_SCLK/ADC_CS_N/ADC_DIN/ADC_DOUT interface driven by the scope's ADC controller. Its uses are loopback test of the capture path without the analog front end, and a bit-accurate bench model. Channel data comes from a parallel source that the responder addresses, for example the sine test-wave generator or a constant pattern.

---
 rtl/adc_spi_responder_if.sv | 22 ++
 rtl/adc_spi_responder.sv | 140 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/adc_spi_responder_if.sv
// Pad-side SPI signals plus the parallel channel-data port of the ADC emulator.
interface adc_spi_responder_if;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic        adc_din;
  logic        adc_dout;
  logic [2:0]  chan_addr;
  logic [11:0] chan_data;
  logic [11:0] ctrl_word;
  logic        ctrl_valid;
  logic        frame_err;

  modport slave (
    input  adc_cs_n, adc_sclk, adc_din, chan_data,
    output adc_dout, chan_addr, ctrl_word, ctrl_valid, frame_err
  );

  modport master (
    output adc_cs_n, adc_sclk, adc_din, chan_data,
    input  adc_dout, chan_addr, ctrl_word, ctrl_valid, frame_err
  );
endinterface

// File: rtl/adc_spi_responder.sv
// AD7928-style SPI responder: shifts {0, addr, sample} out on DOUT and
// captures the 16-bit DIN control frame, all oversampled on the system clock.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clock,
  input  logic                i_reset,
  adc_spi_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_din_sync, r_live;
  logic                   r_cs_d, r_sclk_d, r_armed;

  logic w_cs, w_sclk, w_din;
  logic w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;

  state_t      r_state;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_shift_in, r_shift_out;
  logic        r_dout, r_ctrl_valid, r_frame_err;
  logic [2:0]  r_chan_addr;
  logic [11:0] r_ctrl_word;
  logic [15:0] w_load;

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_din  = r_din_sync[SYNC_STAGES-1];

  // Synchronizers preset to idle levels; r_live marks when the chain output
  // reflects the pad again, so a CS_N already low at reset exit is not a frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '1;
      r_din_sync  <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b1;
      r_live      <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bus.adc_cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.adc_sclk};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  bus.adc_din};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
      r_live      <= {r_live[SYNC_STAGES-2:0], 1'b1};
      if (r_live[SYNC_STAGES-1] && w_cs)
        r_armed <= 1'b1;
    end
  end

  assign w_cs_fall   = r_armed & r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  assign w_load = {1'b0, r_chan_addr, bus.chan_data};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift_in   <= '0;
      r_shift_out  <= '0;
      r_dout       <= 1'b0;
      r_chan_addr  <= '0;
      r_ctrl_word  <= '0;
      r_ctrl_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_ctrl_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_dout <= 1'b0;
          if (w_cs_fall) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shift_out <= w_load;
          r_dout      <= w_load[15];
          r_bit_cnt   <= '0;
          r_shift_in  <= '0;
          if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_dout      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_cs_fall) begin
            r_frame_err <= 1'b1;
            r_state     <= S_LOAD;
          end else if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_dout      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_sclk_rise) begin
            r_shift_in <= {r_shift_in[14:0], w_din};
            r_bit_cnt  <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd15) begin
              r_dout  <= 1'b0;
              r_state <= S_DONE;
            end
          // A fall before the first rise is the master settling, not a bit.
          end else if (w_sclk_fall && r_bit_cnt != 5'd0 && r_bit_cnt < 5'd16) begin
            r_shift_out <= {r_shift_out[14:0], 1'b0};
            r_dout      <= r_shift_out[14];
          end
        end
        S_DONE: begin
          r_dout <= 1'b0;
          if (w_cs_fall) begin
            r_frame_err <= 1'b1;
            r_state     <= S_LOAD;
          end else if (w_cs_rise) begin
            r_ctrl_word  <= r_shift_in[15:4];
            r_ctrl_valid <= 1'b1;
            if (r_shift_in[15]) r_chan_addr <= r_shift_in[12:10];
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^{r_shift_in[3:0], r_shift_out[15]};

  assign bus.adc_dout   = r_dout;
  assign bus.chan_addr  = r_chan_addr;
  assign bus.ctrl_word  = r_ctrl_word;
  assign bus.ctrl_valid = r_ctrl_valid;
  assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized SPI-master bench for adc_spi_responder with a frame-level model.
module tb_adc_spi_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  adc_spi_responder_if bus ();

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  logic [11:0] chan_tbl [8];
  assign bus.chan_data = chan_tbl[bus.chan_addr];

  // frame-level model
  logic [2:0]  m_addr;
  logic [11:0] m_ctrl;
  int          m_valid, m_err;
  int          n_valid, n_err;
  bit          chk_en;
  int          checks, errors;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One master frame of ncyc SCLK periods; data read is checked against the model.
  task automatic frame(input logic [15:0] din_w, input int ncyc, output logic [15:0] rd);
    logic [15:0] exp_rd, mask;
    int nbits;
    exp_rd = {1'b0, m_addr, chan_tbl[m_addr]};
    rd = '0;
    chk_en = 1'b0;
    clocks(1);
    bus.adc_cs_n = 1'b0;
    clocks(8);
    for (int i = 0; i < ncyc; i++) begin
      bus.adc_sclk = 1'b0;
      bus.adc_din  = (i < 16) ? din_w[15-i] : 1'($urandom_range(0, 1));
      clocks(5);
      if (i < 16) rd[15-i] = bus.adc_dout;
      else        chk("dout_overrun", {31'd0, bus.adc_dout}, 32'd0);
      bus.adc_sclk = 1'b1;
      clocks(5);
    end
    nbits = (ncyc < 16) ? ncyc : 16;
    mask  = 16'hFFFF << (16 - nbits);
    chk("rd_word", {16'd0, rd & mask}, {16'd0, exp_rd & mask});
    bus.adc_cs_n = 1'b1;
    bus.adc_din  = 1'b0;
    clocks(8);
    if (ncyc >= 16) begin
      m_ctrl = din_w[15:4];
      if (din_w[15]) m_addr = din_w[12:10];
      m_valid++;
    end else begin
      m_err++;
    end
    chk("valid_cnt", n_valid, m_valid);
    chk("err_cnt", n_err, m_err);
    chk_en = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] w;
    int nc;
    checks = 0; errors = 0;
    m_addr = 3'd0; m_ctrl = 12'h000; m_valid = 0; m_err = 0;
    n_valid = 0; n_err = 0; chk_en = 1'b0;
    bus.adc_cs_n = 1'b1; bus.adc_sclk = 1'b1; bus.adc_din = 1'b0;
    for (int i = 0; i < 8; i++) chan_tbl[i] = 12'($urandom);
    chan_tbl[0] = 12'hABC;
    chan_tbl[3] = 12'h123;

    // Background compare: pulse counting and idle-state outputs every cycle.
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.ctrl_valid) n_valid++;
          if (bus.frame_err)  n_err++;
          if (chk_en) begin
            chk("idle_addr", {29'd0, bus.chan_addr}, {29'd0, m_addr});
            chk("idle_ctrl", {20'd0, bus.ctrl_word}, {20'd0, m_ctrl});
            chk("idle_dout", {31'd0, bus.adc_dout}, 32'd0);
          end
        end
      end
    join_none

    clocks(3);
    chk("rst_dout",  {31'd0, bus.adc_dout}, 32'd0);
    chk("rst_addr",  {29'd0, bus.chan_addr}, 32'd0);
    chk("rst_ctrl",  {20'd0, bus.ctrl_word}, 32'd0);
    chk("rst_pulse", {30'd0, bus.ctrl_valid, bus.frame_err}, 32'd0);
    rst = 1'b0;
    clocks(4);
    chk_en = 1'b1;

    // basic frame, WRITE=1 ADDR=3
    frame(16'h8C00, 16, rd);
    chk("basic_rd", {16'd0, rd}, 32'h0ABC);
    chk("basic_ctrl", {20'd0, bus.ctrl_word}, 32'h8C0);
    chk("basic_addr", {29'd0, bus.chan_addr}, 32'd3);
    chk("basic_valid", n_valid, 32'd1);

    // WRITE=0 keeps address, returns data for addr 3
    frame(16'h0400, 16, rd);
    chk("w0_rd", {16'd0, rd}, 32'h3123);
    chk("w0_ctrl", {20'd0, bus.ctrl_word}, 32'h040);
    chk("w0_addr", {29'd0, bus.chan_addr}, 32'd3);

    // abort after 9 rising edges
    frame(16'hFFFF, 9, rd);
    chk("abort_err", n_err, 32'd1);
    chk("abort_ctrl", {20'd0, bus.ctrl_word}, 32'h040);
    chk("abort_addr", {29'd0, bus.chan_addr}, 32'd3);
    frame(16'h9400, 16, rd);
    chk("post_abort_rd", {16'd0, rd}, 32'h3123);
    chk("post_abort_addr", {29'd0, bus.chan_addr}, 32'd5);

    // overrun: 20 SCLK cycles
    frame(16'hA800, 20, rd);
    chk("ovr_rd", {16'd0, rd}, {16'd0, 1'b0, 3'd5, chan_tbl[5]});
    chk("ovr_ctrl", {20'd0, bus.ctrl_word}, 32'hA80);
    chk("ovr_addr", {29'd0, bus.chan_addr}, 32'd2);

    // reset mid-frame at bit 7 with CS_N held low
    chk_en = 1'b0;
    bus.adc_cs_n = 1'b0;
    clocks(8);
    for (int i = 0; i < 7; i++) begin
      bus.adc_sclk = 1'b0; bus.adc_din = 1'b1; clocks(5);
      bus.adc_sclk = 1'b1; clocks(5);
    end
    rst = 1'b1;
    clocks(3);
    rst = 1'b0;
    m_addr = 3'd0; m_ctrl = 12'h000;
    clocks(10);
    bus.adc_cs_n = 1'b1;
    bus.adc_din  = 1'b0;
    clocks(8);
    chk("rstmid_err", n_err, m_err);
    chk("rstmid_valid", n_valid, m_valid);
    chk("rstmid_addr", {29'd0, bus.chan_addr}, 32'd0);
    chk_en = 1'b1;
    chan_tbl[0] = 12'h5A5;
    frame(16'h0000, 16, rd);
    chk("rstmid_rd", {16'd0, rd}, 32'h05A5);

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      chan_tbl[$urandom_range(0, 7)] = 12'($urandom);
      w  = 16'($urandom);
      nc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 20));
      frame(w, nc, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
